// File: rtl/csr_ctrl.sv
// Execute-stage sequencer driving the single-port M-mode CSR file for Zicsr, ECALL and MRET.
// Result after 3 (CSR op), 6 (ECALL), 4 (MRET) or 1 (no-op) cycles; held until out_ready, in_ready only in IDLE.
module csr_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_funct3,
   input  logic        in_is_ecall,
   input  logic        in_is_mret,
   input  logic [11:0] in_csr_addr,
   input  logic [4:0]  in_rs1_idx,
   input  logic [31:0] in_rs1_data,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rd_data,
   output logic        out_redirect,
   output logic [31:0] out_redirect_pc,
   output logic        csr_we,
   output logic [11:0] csr_addr,
   output logic [31:0] csr_wdata,
   input  logic [31:0] csr_rdata
);
   localparam logic [11:0] MSTATUS = 12'h300;
   localparam logic [11:0] MTVEC   = 12'h305;
   localparam logic [11:0] MEPC    = 12'h341;
   localparam logic [11:0] MCAUSE  = 12'h342;

   typedef enum logic [3:0] {
      IDLE, C_RD, C_WR,
      E_EPC, E_CAUSE, E_SRD, E_SWR, E_VEC,
      M_EPC, M_SRD, M_SWR,
      DONE
   } state_t;

   state_t      state;
   logic [2:0]  funct3;
   logic [4:0]  rs1_idx;
   logic [31:0] rs1_data;
   logic [31:0] old;
   logic        we;

   logic [31:0] src;
   logic [31:0] csr_new;
   logic        wr_en;
   logic [31:0] st_ecall;
   logic [31:0] st_mret;

   // Read-modify-write values are formed from csr_rdata in the read state and registered at its closing edge.
   always_comb begin
      src = funct3[2] ? {27'b0, rs1_idx} : rs1_data;
      case (funct3[1:0])
         2'b01:   csr_new = src;
         2'b10:   csr_new = csr_rdata | src;
         default: csr_new = csr_rdata & ~src;
      endcase
      wr_en = (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);

      st_ecall        = csr_rdata;
      st_ecall[7]     = csr_rdata[3];
      st_ecall[3]     = 1'b0;
      st_ecall[12:11] = 2'b11;

      st_mret         = csr_rdata;
      st_mret[3]      = csr_rdata[7];
      st_mret[7]      = 1'b1;
      st_mret[12:11]  = 2'b11;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         in_ready        <= 1'b1;
         out_valid       <= 1'b0;
         out_rd_data     <= '0;
         out_redirect    <= 1'b0;
         out_redirect_pc <= '0;
         we              <= 1'b0;
         csr_addr        <= '0;
         csr_wdata       <= '0;
         funct3          <= '0;
         rs1_idx         <= '0;
         rs1_data        <= '0;
         old             <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               in_ready <= 1'b0;
               funct3   <= in_funct3;
               rs1_idx  <= in_rs1_idx;
               rs1_data <= in_rs1_data;
               if (in_is_ecall) begin
                  state     <= E_EPC;
                  we        <= 1'b1;
                  csr_addr  <= MEPC;
                  csr_wdata <= in_pc;
               end else if (in_is_mret) begin
                  state    <= M_EPC;
                  csr_addr <= MEPC;
               end else if (in_funct3[1:0] == 2'b00) begin
                  state       <= DONE;
                  out_rd_data <= '0;
                  out_valid   <= 1'b1;
               end else begin
                  state    <= C_RD;
                  csr_addr <= in_csr_addr;
               end
            end
            C_RD: begin
               old       <= csr_rdata;
               we        <= wr_en;
               csr_wdata <= csr_new;
               state     <= C_WR;
            end
            C_WR: begin
               we          <= 1'b0;
               csr_addr    <= '0;
               csr_wdata   <= '0;
               out_rd_data <= old;
               out_valid   <= 1'b1;
               state       <= DONE;
            end
            E_EPC: begin
               csr_addr  <= MCAUSE;
               csr_wdata <= 32'd11;
               state     <= E_CAUSE;
            end
            E_CAUSE: begin
               we        <= 1'b0;
               csr_addr  <= MSTATUS;
               csr_wdata <= '0;
               state     <= E_SRD;
            end
            E_SRD: begin
               we        <= 1'b1;
               csr_wdata <= st_ecall;
               state     <= E_SWR;
            end
            E_SWR: begin
               we        <= 1'b0;
               csr_addr  <= MTVEC;
               csr_wdata <= '0;
               state     <= E_VEC;
            end
            E_VEC: begin
               csr_addr        <= '0;
               out_redirect_pc <= {csr_rdata[31:2], 2'b00};
               out_redirect    <= 1'b1;
               out_rd_data     <= '0;
               out_valid       <= 1'b1;
               state           <= DONE;
            end
            M_EPC: begin
               out_redirect_pc <= csr_rdata;
               csr_addr        <= MSTATUS;
               state           <= M_SRD;
            end
            M_SRD: begin
               we        <= 1'b1;
               csr_wdata <= st_mret;
               state     <= M_SWR;
            end
            M_SWR: begin
               we           <= 1'b0;
               csr_addr     <= '0;
               csr_wdata    <= '0;
               out_redirect <= 1'b1;
               out_rd_data  <= '0;
               out_valid    <= 1'b1;
               state        <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid       <= 1'b0;
               out_redirect    <= 1'b0;
               out_rd_data     <= '0;
               out_redirect_pc <= '0;
               in_ready        <= 1'b1;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A reset arriving during a write state must keep that write from reaching the file.
   assign csr_we = we & ~rst;

endmodule
